// File: rtl/crc32_eth_byte.sv
// Byte-serial Ethernet CRC-32 (reflected, poly 0xEDB88320) accumulator; 9-edge accept-to-done latency (2 with CRC_PARALLEL_EN).
// No backpressure: start is sampled only in IDLE, one done pulse per accepted byte; running CRC re-seeded only by rst.
module crc32_eth_byte #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY      = 32'hEDB88320,
    parameter logic [CRC_WIDTH-1:0] INIT      = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [CRC_WIDTH-1:0]  CRCOut,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CRC_WIDTH-1:0]    crc_q, crc_d;
    logic [CRC_WIDTH-1:0]    crc_out_q, crc_out_d;
    logic [DATA_WIDTH-1:0]   byte_q, byte_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    done_q, done_d;

    function automatic logic [CRC_WIDTH-1:0] crc_bit(input logic [CRC_WIDTH-1:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? POLY : '0);
    endfunction

`ifdef CRC_PARALLEL_EN
    // Unrolled form of the same LSB-first bit step, so both builds produce identical CRCs.
    function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c,
                                                      input logic [DATA_WIDTH-1:0] d);
        logic [CRC_WIDTH-1:0] r;
        r = c;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r = crc_bit(r, d[i]);
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    byte_d  = DataIn;
                    cnt_d   = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
`ifdef CRC_PARALLEL_EN
                crc_d     = crc_byte(crc_q, byte_q);
                crc_out_d = ~crc_d;
                done_d    = 1'b1;
                state_d   = DONE;
`else
                crc_d  = crc_bit(crc_q, byte_q[0]);
                byte_d = byte_q >> 1;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    crc_out_d = ~crc_d;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            crc_out_q <= ~INIT;
            byte_q    <= '0;
            cnt_q     <= 3'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            byte_q    <= byte_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign CRCOut = crc_out_q;
    assign done   = done_q;

endmodule

// File: tb/tb_crc32_eth_byte.sv
// Directed self-checking bench for crc32_eth_byte; honours CRC_PARALLEL_EN for timing expectations.
module tb_crc32_eth_byte;

`ifdef CRC_PARALLEL_EN
    localparam int DONE_EDGES = 1;   // edges after the accept edge until done is visible
    localparam int PERIOD     = 3;
    localparam int ABORT_WAIT = 0;   // edges after accept to reach the abort point
`else
    localparam int DONE_EDGES = 8;
    localparam int PERIOD     = 10;
    localparam int ABORT_WAIT = 3;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  DataIn;
    logic [31:0] CRCOut;
    logic        done;

    int checks = 0;
    int errors = 0;

    crc32_eth_byte dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .DataIn (DataIn),
        .CRCOut (CRCOut),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Sends one byte, scrambles DataIn while the byte is in flight, checks latency, CRC and pulse width.
    task automatic send_byte(input logic [7:0] b, input logic [31:0] exp_crc, input string tag);
        int k;
        bit seen;
        start  = 1'b1;
        DataIn = b;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        k     = 0;
        while (!seen && k < 30) begin
            DataIn = 8'($urandom);
            tick();
            k++;
            if (done) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(k), 32'(DONE_EDGES));
        check({tag, "_crc"}, CRCOut, exp_crc);
        tick();
        check({tag, "_pulse_width"}, {31'd0, done}, 32'd0);
        check({tag, "_crc_hold"}, CRCOut, exp_crc);
    endtask

    initial begin
        logic [7:0] msg [9];
        int pulses, cyc, last, extra;

        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst    = 1'b1;
        start  = 1'b0;
        DataIn = 8'h00;

        // Reset and idle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_crc", CRCOut, 32'h00000000);
        end

        // Single 0x00
        send_byte(8'h00, 32'hD202EF8D, "byte00");

        // Single 0xFF
        do_reset();
        send_byte(8'hFF, 32'hFF000000, "byteFF");

        // Two zero bytes
        do_reset();
        send_byte(8'h00, 32'hD202EF8D, "zz_first");
        send_byte(8'h00, 32'h41D912FF, "zz_second");

        // "123456789" with start held high
        do_reset();
        start  = 1'b1;
        DataIn = msg[0];
        pulses = 0;
        cyc    = 0;
        last   = 0;
        while (pulses < 9 && cyc < 300) begin
            tick();
            cyc++;
            if (done) begin
                pulses++;
                if (pulses > 1) check("b2b_period", 32'(cyc - last), 32'(PERIOD));
                last = cyc;
                if (pulses < 9) DataIn = msg[pulses];
                else start = 1'b0;
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd9);
        check("b2b_crc", CRCOut, 32'hCBF43926);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) extra++;
        end
        check("b2b_extra_done", 32'(extra), 32'd0);
        check("b2b_crc_hold", CRCOut, 32'hCBF43926);

        // Reset mid-SHIFT aborts the byte
        do_reset();
        extra  = 0;
        start  = 1'b1;
        DataIn = 8'h5A;
        tick();
        start = 1'b0;
        for (int i = 0; i < ABORT_WAIT; i++) begin
            DataIn = 8'($urandom);
            tick();
            if (done) extra++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_done_at_reset", {31'd0, done}, 32'd0);
        check("abort_crc_at_reset", CRCOut, 32'h00000000);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        send_byte(8'h00, 32'hD202EF8D, "after_abort");

        // rst and start on the same edge: reset wins
        do_reset();
        extra  = 0;
        rst    = 1'b1;
        start  = 1'b1;
        DataIn = 8'hFF;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) extra++;
        end
        check("rst_start_no_done", 32'(extra), 32'd0);
        check("rst_start_crc", CRCOut, 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
